// File: rtl/fpu_norm_round.sv
// Normalise / round-to-nearest-even / pack stage for the double-precision multiplier datapath.
// Optional directed rounding modes via `define FPU_NORM_RMODE_EN (adds the rmode port).
module fpu_norm_round #(
    parameter int WIDTH     = 106,
    parameter int WIDTH_LOG = 7,
    parameter int MANT_W    = 53,
    parameter int EXP_W     = 13,
    parameter int BIAS      = 1023
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_mant,
    input  logic [WIDTH_LOG:0]      in_msb,
    input  logic                    in_zero,
    input  logic signed [EXP_W-1:0] in_exp,
    input  logic                    in_sign,
`ifdef FPU_NORM_RMODE_EN
    input  logic [1:0]              rmode,
`endif
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_sign,
    output logic [10:0]             out_exp,
    output logic [MANT_W-1:0]       out_mant,
    output logic                    out_ovf,
    output logic                    out_unf,
    output logic                    out_inexact
);

    localparam int IW = WIDTH_LOG + 1;
    localparam int GI = WIDTH - 1 - MANT_W;
    localparam logic [IW-1:0]          MSB_MAX = IW'(WIDTH - 1);
    localparam logic signed [EXP_W-1:0] EXP_OFF = EXP_W'(BIAS - (WIDTH - 2));
    localparam logic signed [EXP_W-1:0] EXP_INF = EXP_W'(2047);
    localparam logic signed [EXP_W-1:0] EXP_MIN = EXP_W'(1);

    localparam logic [1:0] RM_NEAR = 2'b00;
    localparam logic [1:0] RM_ZERO = 2'b01;
    localparam logic [1:0] RM_PINF = 2'b10;
    localparam logic [1:0] RM_NINF = 2'b11;

    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    logic [1:0] rmode_in;
`ifdef FPU_NORM_RMODE_EN
    assign rmode_in = rmode;
`else
    assign rmode_in = RM_NEAR;
`endif

    // Stage 1 inputs: saturate the encoder index, derive shift and biased exponent.
    logic [IW-1:0]          msb_sat;
    logic [IW-1:0]          shamt_next;
    logic signed [EXP_W-1:0] exp_s1_next;

    assign msb_sat     = (in_msb > MSB_MAX) ? MSB_MAX : in_msb;
    assign shamt_next  = MSB_MAX - msb_sat;
    assign exp_s1_next = in_exp + signed'(EXP_W'(msb_sat)) + EXP_OFF;

    logic                    s1_valid_reg;
    logic [WIDTH-1:0]        s1_mant_reg;
    logic [IW-1:0]           s1_shamt_reg;
    logic signed [EXP_W-1:0] s1_exp_reg;
    logic                    s1_zero_reg;
    logic                    s1_sign_reg;
    logic [1:0]              s1_rmode_reg;

    // Stage 2 inputs: left-justify the product and split off guard/sticky.
    logic [WIDTH-1:0] norm;
    assign norm = s1_mant_reg << s1_shamt_reg;

    logic                    s2_valid_reg;
    logic [MANT_W-1:0]       s2_sig_reg;
    logic                    s2_guard_reg;
    logic                    s2_sticky_reg;
    logic signed [EXP_W-1:0] s2_exp_reg;
    logic                    s2_zero_reg;
    logic                    s2_sign_reg;
    logic [1:0]              s2_rmode_reg;

    // Stage 3: round, detect range exceptions, pack.
    logic                    round_up;
    logic [MANT_W:0]         sum;
    logic                    carry;
    logic [MANT_W-1:0]       sig_rnd;
    logic signed [EXP_W-1:0] e_fin;
    logic                    ovf_to_inf;

    logic              out_sign_next;
    logic [10:0]       out_exp_next;
    logic [MANT_W-1:0] out_mant_next;
    logic              out_ovf_next;
    logic              out_unf_next;
    logic              out_inexact_next;

    always_comb begin
        round_up = 1'b0;
        unique case (s2_rmode_reg)
            RM_NEAR: round_up = s2_guard_reg && (s2_sticky_reg || s2_sig_reg[0]);
            RM_ZERO: round_up = 1'b0;
            RM_PINF: round_up = (s2_guard_reg || s2_sticky_reg) && !s2_sign_reg;
            RM_NINF: round_up = (s2_guard_reg || s2_sticky_reg) && s2_sign_reg;
            default: round_up = 1'b0;
        endcase

        sum     = {1'b0, s2_sig_reg} + {{MANT_W{1'b0}}, round_up};
        carry   = sum[MANT_W];
        sig_rnd = carry ? {1'b1, {(MANT_W-1){1'b0}}} : sum[MANT_W-1:0];
        e_fin   = s2_exp_reg + signed'({{(EXP_W-1){1'b0}}, carry});

        ovf_to_inf = (s2_rmode_reg == RM_NEAR)
                  || ((s2_rmode_reg == RM_PINF) && !s2_sign_reg)
                  || ((s2_rmode_reg == RM_NINF) && s2_sign_reg);

        out_sign_next    = s2_sign_reg;
        out_exp_next     = e_fin[10:0];
        out_mant_next    = sig_rnd;
        out_ovf_next     = 1'b0;
        out_unf_next     = 1'b0;
        out_inexact_next = s2_guard_reg || s2_sticky_reg;

        if (s2_zero_reg) begin
            out_exp_next     = '0;
            out_mant_next    = '0;
            out_inexact_next = 1'b0;
        end else if (e_fin >= EXP_INF) begin
            // Tested after the rounding carry so 2046 rounding up lands here.
            out_ovf_next     = 1'b1;
            out_inexact_next = 1'b1;
            if (ovf_to_inf) begin
                out_exp_next  = 11'd2047;
                out_mant_next = '0;
            end else begin
                out_exp_next  = 11'd2046;
                out_mant_next = '1;
            end
        end else if (e_fin < EXP_MIN) begin
            out_exp_next     = '0;
            out_mant_next    = '0;
            out_unf_next     = 1'b1;
            out_inexact_next = 1'b1;
        end
    end

    logic              out_valid_reg;
    logic              out_sign_reg;
    logic [10:0]       out_exp_reg;
    logic [MANT_W-1:0] out_mant_reg;
    logic              out_ovf_reg;
    logic              out_unf_reg;
    logic              out_inexact_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg    <= 1'b0;
            s2_valid_reg    <= 1'b0;
            out_valid_reg   <= 1'b0;
            out_sign_reg    <= 1'b0;
            out_exp_reg     <= '0;
            out_mant_reg    <= '0;
            out_ovf_reg     <= 1'b0;
            out_unf_reg     <= 1'b0;
            out_inexact_reg <= 1'b0;
        end else if (advance) begin
            s1_valid_reg <= in_valid;
            s1_mant_reg  <= in_mant;
            s1_shamt_reg <= shamt_next;
            s1_exp_reg   <= exp_s1_next;
            s1_zero_reg  <= in_zero;
            s1_sign_reg  <= in_sign;
            s1_rmode_reg <= rmode_in;

            s2_valid_reg  <= s1_valid_reg;
            s2_sig_reg    <= norm[WIDTH-1 -: MANT_W];
            s2_guard_reg  <= norm[GI];
            s2_sticky_reg <= |norm[GI-1:0];
            s2_exp_reg    <= s1_exp_reg;
            s2_zero_reg   <= s1_zero_reg;
            s2_sign_reg   <= s1_sign_reg;
            s2_rmode_reg  <= s1_rmode_reg;

            out_valid_reg   <= s2_valid_reg;
            out_sign_reg    <= out_sign_next;
            out_exp_reg     <= out_exp_next;
            out_mant_reg    <= out_mant_next;
            out_ovf_reg     <= out_ovf_next;
            out_unf_reg     <= out_unf_next;
            out_inexact_reg <= out_inexact_next;
        end
    end

    assign out_valid   = out_valid_reg;
    assign out_sign    = out_sign_reg;
    assign out_exp     = out_exp_reg;
    assign out_mant    = out_mant_reg;
    assign out_ovf     = out_ovf_reg;
    assign out_unf     = out_unf_reg;
    assign out_inexact = out_inexact_reg;

endmodule

// File: tb/tb_fpu_norm_round.sv
// Bench for fpu_norm_round: directed and random beats checked against an arithmetic
// round-half-even model through an in-order scoreboard, with backpressure and reset.
module tb_fpu_norm_round;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [105:0]       in_mant;
    logic [7:0]         in_msb;
    logic               in_zero;
    logic signed [12:0] in_exp;
    logic               in_sign;
    logic               out_valid;
    logic               out_ready;
    logic               out_sign;
    logic [10:0]        out_exp;
    logic [52:0]        out_mant;
    logic               out_ovf;
    logic               out_unf;
    logic               out_inexact;

    always #5 clk = ~clk;

    fpu_norm_round dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mant(in_mant), .in_msb(in_msb), .in_zero(in_zero),
        .in_exp(in_exp), .in_sign(in_sign),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .out_exp(out_exp), .out_mant(out_mant),
        .out_ovf(out_ovf), .out_unf(out_unf), .out_inexact(out_inexact)
    );

    typedef struct packed {
        logic        sign;
        logic [10:0] exp;
        logic [52:0] mant;
        logic        ovf;
        logic        unf;
        logic        inx;
    } res_t;

    res_t exp_q[$];
    int   errors  = 0;
    int   checks  = 0;
    int   emitted = 0;
    bit   mon_en  = 1'b0;
    bit   stalled = 1'b0;
    res_t held;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    // Reference: keep the top 53 bits of the value, round the discarded tail half-to-even.
    function automatic res_t model(input logic [105:0] m, input int p, input int ex,
                                   input logic s, input logic z);
        res_t         r;
        logic [105:0] sig;
        logic [105:0] rem;
        logic [105:0] half;
        logic [105:0] one;
        int           e;
        int           drop;
        bit           up;
        r      = '0;
        r.sign = s;
        if (z) return r;
        one  = 106'd1;
        e    = ex + p - 104 + 1023;
        rem  = '0;
        half = '0;
        if (p >= 53) begin
            drop = p - 52;
            sig  = m >> drop;
            rem  = m & ((one << drop) - one);
            half = one << (drop - 1);
        end else begin
            sig = m << (52 - p);
        end
        up = (rem > half) || ((half != 0) && (rem == half) && sig[0]);
        if (up) sig = sig + one;
        if (sig == (one << 53)) begin
            sig = one << 52;
            e   = e + 1;
        end
        if (e >= 2047) begin
            r.exp = 11'd2047; r.ovf = 1'b1; r.inx = 1'b1;
        end else if (e <= 0) begin
            r.unf = 1'b1; r.inx = 1'b1;
        end else begin
            r.exp  = 11'(e);
            r.mant = sig[52:0];
            r.inx  = (rem != 0);
        end
        return r;
    endfunction

    function automatic logic [105:0] rnd106();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[105:0];
    endfunction

    // Output monitor: scoreboard compare on each handshake, stability check while stalled.
    always @(negedge clk) begin
        res_t cur;
        res_t want;
        cur = {out_sign, out_exp, out_mant, out_ovf, out_unf, out_inexact};
        if (mon_en) begin
            if (stalled) check("hold_stable", 128'(cur), 128'(held));
            if (out_valid && !out_ready) check("in_ready_stall", 128'(in_ready), 128'(0));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_result", 128'(1), 128'(0));
                end else begin
                    want = exp_q.pop_front();
                    check("result", 128'(cur), 128'(want));
                end
                emitted++;
                $display("out #%0d sign=%0b exp=%0d mant=%h ovf=%0b unf=%0b inx=%0b",
                         emitted, out_sign, out_exp, out_mant, out_ovf, out_unf, out_inexact);
            end
            stalled = out_valid && !out_ready;
            held    = cur;
        end else begin
            stalled = 1'b0;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the beat is taken.
    task automatic send(input logic [105:0] m, input int p, input int ex,
                        input logic s, input logic z, input bit track);
        int n;
        n        = 0;
        in_mant  = m;
        in_msb   = 8'(p);
        in_exp   = 13'(ex);
        in_sign  = s;
        in_zero  = z;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 100) begin
                check("accept_timeout", 128'(0), 128'(1));
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        if (track) exp_q.push_back(model(m, p, ex, s, z));
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("drain", 128'(exp_q.size()), 128'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        logic [105:0] one;
        logic [105:0] m;
        logic [105:0] ones;
        logic [52:0]  hid;
        int           p;
        int           ex;
        int           kind;
        bit           done;

        one       = 106'd1;
        hid       = 53'd1 << 52;
        ones      = ((one << 105) - one) ^ ((one << 51) - one);
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_mant   = '0;
        in_msb    = '0;
        in_zero   = 1'b0;
        in_exp    = '0;
        in_sign   = 1'b0;
        out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_data", 128'({out_sign, out_exp, out_mant}), 128'(0));
        check("rst_flags", 128'({out_ovf, out_unf, out_inexact}), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(1));
        @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;

        // 1.0 x 1.0 with exact latency
        send(one << 104, 104, 0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("lat_c1", 128'(out_valid), 128'(0));
        @(negedge clk);
        check("lat_c2", 128'(out_valid), 128'(0));
        @(negedge clk);
        check("lat_c3", 128'(out_valid), 128'(1));
        check("one_exp", 128'(out_exp), 128'(1023));
        check("one_mant", 128'(out_mant), 128'(hid));
        check("one_flags", 128'({out_ovf, out_unf, out_inexact}), 128'(0));
        @(posedge clk);
        #1;

        // Directed: carry-out, zero, ties, range, round into overflow, sticky
        send(one << 105, 105, 0, 1'b0, 1'b0, 1'b1);
        send('0, 0, 0, 1'b1, 1'b1, 1'b1);
        send((one << 104) | (one << 51), 104, 0, 1'b0, 1'b0, 1'b1);
        send((one << 104) | (one << 52) | (one << 51), 104, 0, 1'b0, 1'b0, 1'b1);
        send(ones, 104, 0, 1'b1, 1'b0, 1'b1);
        send(one << 104, 104, 1024, 1'b0, 1'b0, 1'b1);
        send(one << 104, 104, -1023, 1'b1, 1'b0, 1'b1);
        send(ones, 104, 1023, 1'b0, 1'b0, 1'b1);
        send((one << 104) | (one << 51) | one, 104, -5, 1'b0, 1'b0, 1'b1);
        send(one << 3, 3, 100, 1'b0, 1'b0, 1'b1);
        drain();

        // Backpressure: 6 beats, out_ready low for cycles 4-8
        emitted = 0;
        fork
            begin
                for (int i = 1; i <= 6; i++)
                    send((one << 104) | (106'(i) << 60) | 106'(i), 104, i * 10, i[0], 1'b0, 1'b1);
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        repeat (5) @(negedge clk);
        check("bp_count", 128'(emitted), 128'(6));
        @(posedge clk);
        #1;

        // Reset with three beats in flight
        mon_en    = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send((one << 100) | 106'(i), 100, 7, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 128'(out_valid), 128'(0));
        exp_q.delete();
        out_ready = 1'b1;
        @(posedge clk);
        #1 mon_en = 1'b1;
        send((one << 104) | (one << 51) | (one << 7), 104, 3, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("midrst_lat", 128'(out_valid), 128'(1));
        @(posedge clk);
        #1;
        drain();

        // Random beats with random gaps and random backpressure
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 80; i++) begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                    kind = int'($urandom_range(0, 9));
                    ex   = int'($urandom_range(0, 2600)) - 1300;
                    if (kind == 0) begin
                        send('0, int'($urandom_range(0, 105)), ex, 1'($urandom), 1'b1, 1'b1);
                    end else begin
                        p = (kind < 6) ? int'($urandom_range(100, 105)) : int'($urandom_range(0, 105));
                        m = (rnd106() & ((one << p) - one)) | (one << p);
                        send(m, p, ex, 1'($urandom), 1'b0, 1'b1);
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
